ps2_dir_keys: RTL and testbench



---
 rtl/ps2_dir_keys_if.sv | 25 ++
 rtl/ps2_dir_keys.sv | 194 +++++++++++++++++++
 tb/tb_ps2_dir_keys.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_dir_keys_if.sv
// PS/2 keyboard pins and decoded direction/scan outputs.
// master: keyboard/consumer side; slave: the receiver block.
interface ps2_dir_keys_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       left;
   logic       right;
   logic       up;
   logic       down;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       err;

   modport master (
      output ps2_clk, ps2_data,
      input  left, right, up, down,
      input  scan_code, scan_valid, err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output left, right, up, down,
      output scan_code, scan_valid, err
   );
endinterface

// File: rtl/ps2_dir_keys.sv
// PS/2 receiver: sync, glitch filter, frame deframer, make/break
// decoder holding one level per direction (arrows and WASD).
module ps2_dir_keys #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000
) (
   input logic          clk,
   input logic          reset,
   ps2_dir_keys_if.slave bus
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   // held-key bit positions
   localparam int K_LA = 0;
   localparam int K_RA = 1;
   localparam int K_UA = 2;
   localparam int K_DA = 3;
   localparam int K_A  = 4;
   localparam int K_W  = 5;
   localparam int K_S  = 6;
   localparam int K_D  = 7;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync, dat_sync;
   logic          clk_s, dat_s;
   logic [FW-1:0] flt_cnt;
   logic          clk_f, clk_fq, fall;

   state_t        state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par, par_n;
   logic [TW-1:0] tmo;
   logic          good_c, bad_c;

   logic          ext, brk;
   logic [7:0]    held, hit;

   assign clk_s = clk_sync[1];
   assign dat_s = dat_sync[1];
   assign fall  = clk_fq & ~clk_f;

   // two-flop synchronizers for the raw pins (idle high)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], bus.ps2_clk};
         dat_sync <= {dat_sync[0], bus.ps2_data};
      end
   end

   // filtered clock follows only a run of FILTER_LEN differing samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flt_cnt <= '0;
         clk_f   <= 1'b1;
         clk_fq  <= 1'b1;
      end else begin
         clk_fq <= clk_f;
         if (clk_s == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_f   <= clk_s;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   // frame state register and inter-edge watchdog
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         tmo     <= '0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
         par     <= par_n;
         if (fall || state == IDLE)
            tmo <= '0;
         else if (tmo != TW'(TIMEOUT))
            tmo <= tmo + 1'b1;
      end
   end

   // deframer next state; flags good/bad frame at the stop bit
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par;
      good_c    = 1'b0;
      bad_c     = 1'b0;
      if (state != IDLE && tmo == TW'(TIMEOUT)) begin
         state_n = IDLE;
         bad_c   = 1'b1;
      end else if (fall) begin
         unique case (state)
            IDLE: begin
               if (!dat_s) begin
                  bit_cnt_n = '0;
                  state_n   = DATA;
               end
            end
            DATA: begin
               shreg_n   = {dat_s, shreg[7:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7)
                  state_n = PARITY;
            end
            PARITY: begin
               par_n   = dat_s;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (dat_s && ^{shreg, par})
                  good_c = 1'b1;
               else
                  bad_c = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // registered byte output and status pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.scan_code  <= '0;
         bus.scan_valid <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.scan_valid <= good_c;
         bus.err        <= bad_c;
         if (good_c)
            bus.scan_code <= shreg;
      end
   end

   // key lookup for the byte currently presented
   always_comb begin
      hit = '0;
      unique case (1'b1)
         ext  && bus.scan_code == 8'h6B: hit[K_LA] = 1'b1;
         ext  && bus.scan_code == 8'h74: hit[K_RA] = 1'b1;
         ext  && bus.scan_code == 8'h75: hit[K_UA] = 1'b1;
         ext  && bus.scan_code == 8'h72: hit[K_DA] = 1'b1;
         !ext && bus.scan_code == 8'h1C: hit[K_A]  = 1'b1;
         !ext && bus.scan_code == 8'h1D: hit[K_W]  = 1'b1;
         !ext && bus.scan_code == 8'h1B: hit[K_S]  = 1'b1;
         !ext && bus.scan_code == 8'h23: hit[K_D]  = 1'b1;
         default: ;
      endcase
   end

   // make/break tracking; prefixes latch until the next plain byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext  <= 1'b0;
         brk  <= 1'b0;
         held <= '0;
      end else if (bus.err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (bus.scan_valid) begin
         if (bus.scan_code == 8'hE0) begin
            ext <= 1'b1;
         end else if (bus.scan_code == 8'hF0) begin
            brk <= 1'b1;
         end else begin
            held <= (held & ~hit) | (hit & {8{~brk}});
            ext  <= 1'b0;
            brk  <= 1'b0;
         end
      end
   end

   assign bus.left  = held[K_LA] | held[K_A];
   assign bus.right = held[K_RA] | held[K_D];
   assign bus.up    = held[K_UA] | held[K_W];
   assign bus.down  = held[K_DA] | held[K_S];

endmodule

// File: tb/tb_ps2_dir_keys.sv
// Bench for ps2_dir_keys: keyboard frame driver, reference key
// model feeding an event scoreboard, direction level checks.
module tb_ps2_dir_keys;

   localparam int H  = 20;
   localparam int FL = 8;
   localparam int TO = 200;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      logic [3:0] dirs;
   } ev_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ps2_dir_keys_if bus();

   ps2_dir_keys #(
      .FILTER_LEN(FL),
      .TIMEOUT   (TO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   ev_t        q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         m_ext, m_brk;
   logic [7:0] m_held;
   logic [3:0] dirs_now;

   assign dirs_now = {bus.left, bus.right, bus.up, bus.down};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // expected {left,right,up,down}; bits: LA RA UA DA A W S D
   function automatic logic [3:0] m_dirs();
      return {m_held[0] | m_held[4], m_held[1] | m_held[7],
              m_held[2] | m_held[5], m_held[3] | m_held[6]};
   endfunction

   task automatic model_byte(input logic [7:0] b);
      int  k;
      ev_t e;
      k = -1;
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         if (m_ext) begin
            case (b)
               8'h6B: k = 0;
               8'h74: k = 1;
               8'h75: k = 2;
               8'h72: k = 3;
               default: ;
            endcase
         end else begin
            case (b)
               8'h1C: k = 4;
               8'h1D: k = 5;
               8'h1B: k = 6;
               8'h23: k = 7;
               default: ;
            endcase
         end
         if (k >= 0) m_held[k] = !m_brk;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      e.is_err = 1'b0;
      e.code   = b;
      e.dirs   = m_dirs();
      q.push_back(e);
   endtask

   task automatic model_err();
      ev_t e;
      m_ext    = 1'b0;
      m_brk    = 1'b0;
      e.is_err = 1'b1;
      e.code   = 8'h00;
      e.dirs   = m_dirs();
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      bus.ps2_data = b;
      tick(H);
      bus.ps2_clk = 1'b0;
      tick(H);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input bit badpar);
      if (badpar) model_err();
      else model_byte(b);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ badpar);
      ps2_bit(1'b1);
      bus.ps2_data = 1'b1;
      tick(3 * H);
   endtask

   // scoreboard: every pulse must match the next expected event
   ev_t        mon_e;
   bit         pend;
   logic [3:0] pend_dirs, prev_dirs;
   logic [7:0] last_code;

   always @(negedge clk) begin
      if (!reset) begin
         pend      = 1'b0;
         prev_dirs = 4'h0;
         last_code = 8'h00;
      end else begin
         if (pend) begin
            chk("dirs_after", dirs_now, pend_dirs);
            pend = 1'b0;
         end
         if (bus.scan_valid || bus.err) begin
            if (q.size() == 0) begin
               chk("unexpected_evt", {bus.err, bus.scan_valid}, 0);
            end else begin
               mon_e = q.pop_front();
               chk("evt_kind", {bus.err, bus.scan_valid},
                   {mon_e.is_err, !mon_e.is_err});
               if (mon_e.is_err) begin
                  chk("code_hold", bus.scan_code, last_code);
               end else begin
                  chk("scan_code", bus.scan_code, mon_e.code);
                  last_code = mon_e.code;
               end
               chk("dirs_before", dirs_now, prev_dirs);
               pend_dirs = mon_e.dirs;
               prev_dirs = mon_e.dirs;
               pend      = 1'b1;
            end
         end
      end
   end

   initial begin
      int w;
      reset        = 1'b0;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      m_ext        = 1'b0;
      m_brk        = 1'b0;
      m_held       = 8'h00;
      tick(5);
      chk("rst_dirs", dirs_now, 4'h0);
      chk("rst_code", bus.scan_code, 8'h00);
      chk("rst_pulses", {bus.scan_valid, bus.err}, 2'b00);
      reset = 1'b1;
      tick(5);

      send(8'hE0, 0);
      send(8'h6B, 0);
      chk("left_make", dirs_now, 4'b1000);

      send(8'hE0, 0);
      send(8'hF0, 0);
      send(8'h6B, 0);
      chk("left_break", dirs_now, 4'b0000);
      send(8'h1C, 0);
      chk("a_make", dirs_now, 4'b1000);

      send(8'h1D, 0);
      send(8'hE0, 0);
      send(8'h75, 0);
      chk("up_both", dirs_now, 4'b1010);
      send(8'hF0, 0);
      send(8'h1D, 0);
      chk("up_arrow_only", dirs_now, 4'b1010);
      send(8'hE0, 0);
      send(8'hF0, 0);
      send(8'h75, 0);
      chk("up_release", dirs_now, 4'b1000);
      send(8'h1C, 0);
      chk("a_typematic", dirs_now, 4'b1000);
      send(8'hF0, 0);
      send(8'h1C, 0);
      chk("a_release", dirs_now, 4'b0000);

      send(8'hE0, 0);
      send(8'h6B, 1);
      send(8'h6B, 0);
      chk("err_clears_ext", dirs_now, 4'b0000);
      send(8'hE0, 0);
      send(8'h6B, 0);
      chk("left_again", dirs_now, 4'b1000);
      send(8'hE0, 0);
      send(8'hF0, 0);
      send(8'h6B, 0);

      model_err();
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(i[0]);
      bus.ps2_data = 1'b1;
      tick(TO + 100);
      chk("tmo_drained", q.size(), 0);
      send(8'h23, 0);
      chk("d_after_tmo", dirs_now, 4'b0100);

      bus.ps2_data = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.ps2_clk = 1'b0;
         tick(5);
         bus.ps2_clk = 1'b1;
         tick(20);
      end
      bus.ps2_data = 1'b1;
      tick(20);
      chk("glitch_quiet", q.size(), 0);
      send(8'hE0, 0);
      send(8'h72, 0);
      chk("down_after_glitch", dirs_now, 4'b0101);

      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      reset = 1'b0;
      m_held = 8'h00;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      tick(3);
      chk("midrst_dirs", dirs_now, 4'h0);
      chk("midrst_code", bus.scan_code, 8'h00);
      bus.ps2_data = 1'b1;
      tick(5);
      reset = 1'b1;
      tick(3 * H);
      send(8'h1B, 0);
      chk("s_after_rst", dirs_now, 4'b0001);
      send(8'hF0, 0);
      send(8'h1B, 0);
      chk("s_release", dirs_now, 4'b0000);

      w = 0;
      while (q.size() != 0 && w < 1000) begin
         tick(1);
         w++;
      end
      chk("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
